// File: rtl/pipe_hazard_unit.sv
// Pipeline hazard unit for a classic 5-stage in-order core.
// Tracks the instructions in EX..WB in a small scoreboard and, from it and the
// instruction in ID, produces stall/flush controls and operand-forward selects.
//
// Ports
//   clk, reset            rising-edge clock, synchronous active-high reset
//   id_*                  decoded fields of the instruction currently in ID
//   br_taken              ID branch comparator result
//   mem_busy              data memory not ready; freezes the whole pipeline
//   stall                 hazard stall request
//   pc_write, if_id_write front-end write enables
//   if_flush              squash the instruction being fetched (jump / taken branch)
//   id_ex_flush           insert a bubble into EX
//   fwd_a, fwd_b          EX operand forward source (stage index, 0 = regfile)
//   fwd_id_a, fwd_id_b    ID branch comparator forward source (stage index, 0 = regfile)
//   stall_cnt             saturating count of stall/freeze cycles
module pipe_hazard_unit #(
  parameter int unsigned AW     = 5,
  parameter int unsigned NSTG   = 3,
  parameter int unsigned LD_LAT = 1,
  parameter int unsigned FW     = $clog2(NSTG + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          id_valid,
  input  logic [AW-1:0] id_rs,
  input  logic [AW-1:0] id_rt,
  input  logic          id_uses_rs,
  input  logic          id_uses_rt,
  input  logic          id_wr,
  input  logic [AW-1:0] id_rd,
  input  logic          id_is_load,
  input  logic          id_is_branch,
  input  logic          br_taken,
  input  logic          id_jump,
  input  logic          mem_busy,
  output logic          stall,
  output logic          pc_write,
  output logic          if_id_write,
  output logic          if_flush,
  output logic          id_ex_flush,
  output logic [FW-1:0] fwd_a,
  output logic [FW-1:0] fwd_b,
  output logic [FW-1:0] fwd_id_a,
  output logic [FW-1:0] fwd_id_b,
  output logic [15:0]   stall_cnt
);

  localparam int unsigned          CNT_W   = 16;
  localparam logic [CNT_W-1:0]     CNT_MAX = '1;

  // One scoreboard slot: the decoded facts about an in-flight instruction.
  typedef struct packed {
    logic          valid;
    logic          wr;
    logic [AW-1:0] rd;
    logic          is_load;
    logic [AW-1:0] rs;
    logic [AW-1:0] rt;
    logic          uses_rs;
    logic          uses_rt;
  } entry_t;

  // e_q[1] = EX, e_q[2] = MEM, ..., e_q[NSTG] = WB
  entry_t            e_q [1:NSTG];
  entry_t            e_d [1:NSTG];
  logic              flushed_q;
  logic              flushed_d;
  logic [CNT_W-1:0]  stall_cnt_q;
  logic [CNT_W-1:0]  stall_cnt_d;

  logic              id_hit_c [1:NSTG];
  logic              hazard_c;
  logic              redirect_c;
  logic [FW-1:0]     fwd_a_c;
  logic [FW-1:0]     fwd_b_c;
  logic [FW-1:0]     fwd_id_a_c;
  logic [FW-1:0]     fwd_id_b_c;

  // A slot produces 'src' when it is live, writes, targets src, and src is not $0.
  function automatic logic src_match(entry_t e, logic [AW-1:0] src);
    return e.valid & e.wr & (e.rd == src) & (src != '0);
  endfunction

  // Youngest producer of 'src' among MEM..WB; 0 means read the register file.
  function automatic logic [FW-1:0] youngest_writer(logic [AW-1:0] src);
    logic [FW-1:0] sel;
    sel = '0;
    for (int k = int'(NSTG); k >= 2; k--) begin
      if (src_match(e_q[k], src)) sel = FW'(k);
    end
    return sel;
  endfunction

  // Per-stage: does that stage produce a source the ID instruction actually reads.
  always_comb begin
    for (int j = 1; j <= int'(NSTG); j++) begin
      id_hit_c[j] = (id_uses_rs & src_match(e_q[j], id_rs)) |
                    (id_uses_rt & src_match(e_q[j], id_rt));
    end
  end

  // Load-use and branch-operand hazards.
  always_comb begin
    hazard_c = 1'b0;
    for (int j = 1; j <= int'(NSTG); j++) begin
      // Load data is not forwardable until it has left stage LD_LAT.
      if (id_valid && id_hit_c[j] && e_q[j].is_load && (j <= int'(LD_LAT))) begin
        hazard_c = 1'b1;
      end
      // The ID comparator cannot take EX results, and load data one stage later still.
      if (id_is_branch && id_hit_c[j] &&
          ((j == 1) || (e_q[j].is_load && (j < int'(LD_LAT) + 2)))) begin
        hazard_c = 1'b1;
      end
    end
  end

  assign redirect_c = id_valid & (id_jump | (id_is_branch & br_taken)) & ~hazard_c & ~mem_busy;

  assign fwd_a_c    = youngest_writer(e_q[1].rs);
  assign fwd_b_c    = youngest_writer(e_q[1].rt);
  assign fwd_id_a_c = youngest_writer(id_rs);
  assign fwd_id_b_c = youngest_writer(id_rt);

  // Output controls; reset forces the pipeline into a free-running, no-forward state.
  always_comb begin
    stall       = 1'b0;
    pc_write    = 1'b1;
    if_id_write = 1'b1;
    if_flush    = 1'b0;
    id_ex_flush = 1'b0;
    fwd_a       = '0;
    fwd_b       = '0;
    fwd_id_a    = '0;
    fwd_id_b    = '0;
    if (!reset) begin
      stall       = hazard_c;
      pc_write    = ~(hazard_c | mem_busy);
      if_id_write = ~(hazard_c | mem_busy);
      if_flush    = redirect_c;
      id_ex_flush = hazard_c & ~mem_busy;
      fwd_a       = fwd_a_c;
      fwd_b       = fwd_b_c;
      fwd_id_a    = fwd_id_a_c;
      fwd_id_b    = fwd_id_b_c;
    end
  end

  // Scoreboard advance, flushed-slot tracking and stall counter.
  always_comb begin
    e_d         = e_q;
    flushed_d   = flushed_q;
    stall_cnt_d = stall_cnt_q;

    if ((hazard_c || mem_busy) && (stall_cnt_q != CNT_MAX)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end

    if (!mem_busy) begin
      for (int k = int'(NSTG); k >= 2; k--) begin
        e_d[k] = e_q[k-1];
      end
      // Bubbles are all-zero so a bubble in EX never requests forwarding.
      if (hazard_c || !id_valid || flushed_q) begin
        e_d[1] = '0;
      end else begin
        e_d[1].valid   = 1'b1;
        e_d[1].wr      = id_wr;
        e_d[1].rd      = id_rd;
        e_d[1].is_load = id_is_load;
        e_d[1].rs      = id_rs;
        e_d[1].rt      = id_rt;
        e_d[1].uses_rs = id_uses_rs;
        e_d[1].uses_rt = id_uses_rt;
      end
      // While stalled IF/ID is held, so the flushed marking stays with the held slot.
      if (!hazard_c) flushed_d = redirect_c;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 1; k <= int'(NSTG); k++) begin
        e_q[k] <= '0;
      end
      flushed_q   <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      e_q         <= e_d;
      flushed_q   <= flushed_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_unit.sv
module tb_pipe_hazard_unit;

  localparam int AW     = 5;
  localparam int NSTG   = 3;
  localparam int LD_LAT = 1;
  localparam int FW     = $clog2(NSTG + 1);

  logic          clk = 1'b0;
  logic          reset;
  logic          id_valid;
  logic [AW-1:0] id_rs;
  logic [AW-1:0] id_rt;
  logic          id_uses_rs;
  logic          id_uses_rt;
  logic          id_wr;
  logic [AW-1:0] id_rd;
  logic          id_is_load;
  logic          id_is_branch;
  logic          br_taken;
  logic          id_jump;
  logic          mem_busy;
  logic          stall;
  logic          pc_write;
  logic          if_id_write;
  logic          if_flush;
  logic          id_ex_flush;
  logic [FW-1:0] fwd_a;
  logic [FW-1:0] fwd_b;
  logic [FW-1:0] fwd_id_a;
  logic [FW-1:0] fwd_id_b;
  logic [15:0]   stall_cnt;

  always #5 clk = ~clk;

  pipe_hazard_unit #(.AW(AW), .NSTG(NSTG), .LD_LAT(LD_LAT), .FW(FW)) dut (
    .clk(clk), .reset(reset),
    .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .id_wr(id_wr), .id_rd(id_rd), .id_is_load(id_is_load),
    .id_is_branch(id_is_branch), .br_taken(br_taken), .id_jump(id_jump),
    .mem_busy(mem_busy),
    .stall(stall), .pc_write(pc_write), .if_id_write(if_id_write),
    .if_flush(if_flush), .id_ex_flush(id_ex_flush),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .fwd_id_a(fwd_id_a), .fwd_id_b(fwd_id_b),
    .stall_cnt(stall_cnt)
  );

  // Reference model: the in-flight instructions as a queue, sb[0] = EX, youngest first.
  typedef struct {
    bit v;
    bit wr;
    int rd;
    bit ld;
    int rs;
    int rt;
  } instr_t;

  instr_t sb[$];
  bit     m_flushed;
  int     m_cnt;
  bit     m_hz;
  bit     m_fl;
  bit     m_busy;
  int     n_assert = 0;
  int     n_fail   = 0;
  int     c0;

  function automatic instr_t bubble();
    instr_t b;
    b = '{default: 0};
    return b;
  endfunction

  function automatic bit writes(instr_t p, int src);
    return p.v && p.wr && (p.rd == src) && (src != 0);
  endfunction

  // Stage number (2..NSTG) of the youngest writer past EX, or 0.
  function automatic int nearest_writer(int src);
    for (int i = 1; i < NSTG; i++) begin
      if (writes(sb[i], src)) return i + 1;
    end
    return 0;
  endfunction

  function automatic bit hazard_expected();
    bit h;
    bit reads;
    h = 0;
    for (int i = 0; i < NSTG; i++) begin
      reads = (id_uses_rs && writes(sb[i], int'(id_rs))) ||
              (id_uses_rt && writes(sb[i], int'(id_rt)));
      if (reads && id_valid && sb[i].ld && (i + 1 <= LD_LAT)) h = 1;
      if (reads && id_is_branch && ((i == 0) || (sb[i].ld && (i + 1 < 2 + LD_LAT)))) h = 1;
    end
    return h;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit v, input int rs, input int rt, input bit urs, input bit urt,
                       input bit wr, input int rd, input bit ld, input bit br, input bit tk,
                       input bit j);
    id_valid     = v;
    id_rs        = AW'(rs);
    id_rt        = AW'(rt);
    id_uses_rs   = urs;
    id_uses_rt   = urt;
    id_wr        = wr;
    id_rd        = AW'(rd);
    id_is_load   = ld;
    id_is_branch = br;
    br_taken     = tk;
    id_jump      = j;
  endtask

  task automatic nop();                        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); endtask
  task automatic alu(input int rs, input int rt, input int rd);
    drive(1, rs, rt, 1, 1, 1, rd, 0, 0, 0, 0);
  endtask
  task automatic lw(input int rs, input int rd); drive(1, rs, 0, 1, 0, 1, rd, 1, 0, 0, 0); endtask
  task automatic beq(input int rs, input int rt, input bit tk);
    drive(1, rs, rt, 1, 1, 0, 0, 0, 1, tk, 0);
  endtask

  // Let inputs settle, then compare every output against the model.
  task automatic settle_check();
    bit e_st, e_pcw, e_fl, e_idx;
    int ea, eb, eia, eib;
    #1;
    m_hz   = hazard_expected();
    m_busy = mem_busy;
    m_fl   = id_valid && (id_jump || (id_is_branch && br_taken)) && !m_hz && !m_busy;
    if (reset) begin
      e_st = 0; e_pcw = 1; e_fl = 0; e_idx = 0;
      ea = 0; eb = 0; eia = 0; eib = 0;
    end else begin
      e_st  = m_hz;
      e_pcw = !(m_hz || m_busy);
      e_fl  = m_fl;
      e_idx = m_hz && !m_busy;
      ea    = nearest_writer(sb[0].rs);
      eb    = nearest_writer(sb[0].rt);
      eia   = nearest_writer(int'(id_rs));
      eib   = nearest_writer(int'(id_rt));
    end
    chk("stall",       32'(stall),       32'(e_st));
    chk("pc_write",    32'(pc_write),    32'(e_pcw));
    chk("if_id_write", 32'(if_id_write), 32'(e_pcw));
    chk("if_flush",    32'(if_flush),    32'(e_fl));
    chk("id_ex_flush", 32'(id_ex_flush), 32'(e_idx));
    chk("fwd_a",       32'(fwd_a),       32'(ea));
    chk("fwd_b",       32'(fwd_b),       32'(eb));
    chk("fwd_id_a",    32'(fwd_id_a),    32'(eia));
    chk("fwd_id_b",    32'(fwd_id_b),    32'(eib));
    chk("stall_cnt",   32'(stall_cnt),   32'(m_cnt));
  endtask

  // Apply the clock edge to the model, then to the DUT.
  task automatic advance();
    instr_t nw;
    if (reset) begin
      for (int i = 0; i < NSTG; i++) sb[i] = bubble();
      m_cnt     = 0;
      m_flushed = 0;
    end else begin
      if (m_hz || m_busy) m_cnt = (m_cnt >= 65535) ? 65535 : m_cnt + 1;
      if (!m_busy) begin
        if (m_hz || !id_valid || m_flushed) nw = bubble();
        else nw = '{v: 1'b1, wr: id_wr, rd: int'(id_rd), ld: id_is_load,
                    rs: int'(id_rs), rt: int'(id_rt)};
        sb.push_front(nw);
        void'(sb.pop_back());
        if (!m_hz) m_flushed = m_fl;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic nops(input int n);
    for (int i = 0; i < n; i++) begin
      nop();
      settle_check();
      advance();
    end
  endtask

  initial begin
    reset    = 1'b1;
    mem_busy = 1'b0;
    nop();
    @(posedge clk);
    #1;
    for (int i = 0; i < NSTG; i++) sb.push_back(bubble());
    m_cnt     = 0;
    m_flushed = 0;

    // Reset state
    settle_check();
    chk("rst_pc_write", 32'(pc_write), 32'd1);
    chk("rst_cnt", 32'(stall_cnt), 32'd0);
    advance();
    reset = 1'b0;
    nops(1);

    // Load-use: lw $8 ; add $9,$8,$8
    lw(0, 8);      settle_check(); advance();
    alu(8, 8, 9);  settle_check();
    chk("lu_stall", 32'(stall), 32'd1);
    chk("lu_idex_flush", 32'(id_ex_flush), 32'd1);
    advance();
    settle_check();
    chk("lu_stall_once", 32'(stall), 32'd0);
    chk("lu_cnt", 32'(stall_cnt), 32'd1);
    advance();
    nop(); settle_check();
    chk("lu_fwd_a", 32'(fwd_a), 32'd3);
    chk("lu_fwd_b", 32'(fwd_b), 32'd3);
    advance();
    nops(3);

    // ALU chain: add $8 ; sub $10,$8,$1
    alu(1, 2, 8);  settle_check(); advance();
    alu(8, 1, 10); settle_check();
    chk("alu_no_stall", 32'(stall), 32'd0);
    advance();
    nop(); settle_check();
    chk("alu_fwd_a", 32'(fwd_a), 32'd2);
    chk("alu_fwd_b", 32'(fwd_b), 32'd0);
    advance();
    nops(3);

    // Branch after ALU: add $8 ; beq $8,$0 (taken)
    alu(1, 2, 8);  settle_check(); advance();
    beq(8, 0, 1);  settle_check();
    chk("br_stall", 32'(stall), 32'd1);
    chk("br_no_flush_while_stalled", 32'(if_flush), 32'd0);
    advance();
    settle_check();
    chk("br_resolved", 32'(stall), 32'd0);
    chk("br_fwd_id_a", 32'(fwd_id_a), 32'd2);
    chk("br_if_flush", 32'(if_flush), 32'd1);
    advance();
    nop(); settle_check();
    chk("br_flush_once", 32'(if_flush), 32'd0);
    advance();
    nops(3);

    // Register 0 never forwards; youngest writer wins
    alu(1, 2, 0);  settle_check(); advance();
    alu(0, 0, 5);  settle_check(); advance();
    nop(); settle_check();
    chk("r0_fwd_a", 32'(fwd_a), 32'd0);
    advance();
    alu(1, 2, 7);  settle_check(); advance();
    alu(3, 4, 7);  settle_check(); advance();
    alu(7, 0, 9);  settle_check(); advance();
    nop(); settle_check();
    chk("youngest_fwd_a", 32'(fwd_a), 32'd2);
    advance();
    nops(3);

    // Freeze during a load-use stall
    lw(0, 8);      settle_check(); advance();
    c0 = m_cnt;
    alu(8, 8, 9);
    mem_busy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      settle_check();
      chk("frz_stall", 32'(stall), 32'd1);
      chk("frz_pc_write", 32'(pc_write), 32'd0);
      chk("frz_idex_flush", 32'(id_ex_flush), 32'd0);
      advance();
    end
    mem_busy = 1'b0;
    settle_check();
    chk("frz_cnt", 32'(stall_cnt), 32'(c0 + 4));
    chk("frz_then_stall", 32'(stall), 32'd1);
    advance();
    settle_check();
    chk("frz_resume", 32'(stall), 32'd0);
    advance();
    nop(); settle_check();
    chk("frz_fwd_a", 32'(fwd_a), 32'd3);
    advance();
    nops(3);

    // Reset in the middle of a stall with stall_cnt = 5
    reset = 1'b1; nop(); settle_check(); advance();
    reset = 1'b0;
    lw(0, 8);      settle_check(); advance();
    alu(8, 8, 9);
    mem_busy = 1'b1;
    for (int i = 0; i < 5; i++) begin
      settle_check();
      advance();
    end
    settle_check();
    chk("mid_stall", 32'(stall), 32'd1);
    chk("mid_cnt", 32'(stall_cnt), 32'd5);
    reset = 1'b1;
    settle_check();
    chk("in_rst_stall", 32'(stall), 32'd0);
    advance();
    reset    = 1'b0;
    mem_busy = 1'b0;
    nop(); settle_check();
    chk("post_rst_cnt", 32'(stall_cnt), 32'd0);
    chk("post_rst_stall", 32'(stall), 32'd0);
    chk("post_rst_fwd_a", 32'(fwd_a), 32'd0);
    advance();

    // Randomized traffic against the model
    for (int i = 0; i < 800; i++) begin
      int kind;
      int rs, rt, rd;
      bit v;
      kind = int'($urandom_range(0, 4));
      rs   = int'($urandom_range(0, 7));
      rt   = int'($urandom_range(0, 7));
      rd   = int'($urandom_range(0, 7));
      v    = ($urandom_range(0, 99) < 85);
      case (kind)
        0: drive(v, rs, rt, 1, $urandom_range(0, 1) == 1, 1, rd, 0, 0, 0, 0);
        1: drive(v, rs, rt, 1, 0, 1, rd, 1, 0, 0, 0);
        2: drive(v, rs, rt, 1, 1, 0, rd, 0, 1, $urandom_range(0, 1) == 1, 0);
        3: drive(v, rs, rt, 0, 0, 0, rd, 0, 0, 0, 1);
        default: drive(v, rs, rt, 1, 1, 0, rd, 0, 0, 0, 0);
      endcase
      mem_busy = ($urandom_range(0, 99) < 15);
      reset    = ($urandom_range(0, 99) < 2);
      settle_check();
      advance();
    end
    reset    = 1'b0;
    mem_busy = 1'b0;
    nops(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_unit.md
PIPE_HAZARD_UNIT -- requirements
Module: pipe_hazard_unit

Interface
REQ-001 The block SHALL have parameter AW, default 5, meaning register-address width.
REQ-002 The block SHALL have parameter NSTG, default 3, meaning the number of post-ID stages tracked: E[1]=EX, E[2]=MEM, ..., E[NSTG]=WB.
REQ-003 The block SHALL have parameter LD_LAT, default 1, meaning the number of stages after EX before load data can be forwarded; the legal range is NSTG >= 2+LD_LAT.
REQ-004 The block SHALL have parameter FW, default $clog2(NSTG+1), meaning forward-select width.
REQ-005 The block SHALL have one clock and a synchronous, active-high reset:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous active-high reset.
REQ-006 The block SHALL have the following ID-stage inputs:
- id_valid  in  1  ID holds a real instruction.
- id_rs, id_rt  in  AW  source registers.
- id_uses_rs, id_uses_rt  in  1  the source is actually read.
- id_wr  in  1  the instruction writes the register file.
- id_rd  in  AW  final destination, after the RegDst mux.
- id_is_load  in  1  lw-class instruction.
- id_is_branch  in  1  beq/bne.
- br_taken  in  1  ID comparator result.
- id_jump  in  1  j.
REQ-007 The block SHALL have input mem_busy  in  1, meaning data memory not ready; it freezes the whole pipeline.
REQ-008 The block SHALL have the following outputs:
- stall  out  1  hazard stall.
- pc_write, if_id_write  out  1  write enables.
- if_flush, id_ex_flush  out  1  flush controls.
- fwd_a, fwd_b  out  FW  EX operand selects.
- fwd_id_a, fwd_id_b  out  FW  ID branch-comparator selects.
- stall_cnt  out  16  stall/freeze cycle counter.

Function
REQ-009 The block SHALL hold a scoreboard E[1..NSTG]; each entry holds {valid, wr, rd, is_load, rs, rt, uses_rs, uses_rt}.
REQ-010 A match SHALL require all of: valid, wr, rd equal to the source, and the source not equal to 0; register 0 SHALL never match.
REQ-011 Load-use: stall SHALL be 1 when id_valid=1 and a used ID source matches a load in E[j] with j <= LD_LAT.
REQ-012 Branch operand hazard: stall SHALL be 1 when id_is_branch=1 and a used source matches either:
- any producer in E[1], or
- a load in E[j] with j < 2+LD_LAT.
REQ-013 fwd_id_a/fwd_id_b SHALL equal the smallest k in 2..NSTG such that E[k] matches the rs/rt source, and 0 when there is no match.
REQ-014 fwd_a/fwd_b SHALL equal the smallest k in 2..NSTG such that E[k] matches E[1].rs/E[1].rt, and 0 when there is no match.
REQ-015 Forward outputs SHALL be purely combinational from the scoreboard and ID inputs, with zero-cycle latency.
REQ-016 On a normal cycle (mem_busy=0, stall=0):
- E[1] SHALL take the ID instruction, or a bubble (valid=0) if id_valid=0 or if_flush=1 was registered for it.
- E[k] SHALL take E[k-1] for k >= 2.
REQ-017 On a stall cycle (mem_busy=0, stall=1):
- E[1] SHALL become a bubble and E[2..NSTG] SHALL shift.
- pc_write=0, if_id_write=0, id_ex_flush=1, if_flush=0.
REQ-018 On a freeze cycle (mem_busy=1), the scoreboard SHALL hold all entries and outputs SHALL be: pc_write=0, if_id_write=0, if_flush=0, id_ex_flush=0; stall keeps its hazard value.
REQ-019 if_flush SHALL equal id_valid & (id_jump | (id_is_branch & br_taken)) & ~stall & ~mem_busy.
REQ-020 Stall SHALL have priority over a taken branch; the branch resolves in the first cycle it is not stalled.
REQ-021 Otherwise pc_write=1 and if_id_write=1.
REQ-022 stall_cnt SHALL increment by 1 on each cycle with stall|mem_busy and saturate at 16'hFFFF.

Reset
REQ-023 When reset=1 at a clk edge, all E[k].valid SHALL become 0 and stall_cnt SHALL become 0.
REQ-024 While reset is asserted, outputs SHALL be: stall=0, pc_write=1, if_id_write=1, if_flush=0, id_ex_flush=0, all forward selects 0.
REQ-025 Reset SHALL override mem_busy and any in-flight stall.

Verification
REQ-026 Load-use: lw $8 then add $9,$8,$8 with defaults -> stall=1 for exactly one cycle, id_ex_flush=1, stall_cnt=1; the next cycle fwd_a=fwd_b=3.
REQ-027 ALU chain: add $8 then sub $10,$8,$1 -> no stall; with sub in EX, fwd_a=2, fwd_b=0.
REQ-028 Branch after ALU: add $8 then beq $8,$0 -> one stall cycle; then fwd_id_a=2 and, with br_taken=1, if_flush=1 for one cycle.
REQ-029 Register 0 and youngest-wins: add $0 then or $5,$0,$0 -> fwd_a=0; two writers of $7 in E[2] and E[3] -> fwd_a=2.
REQ-030 Freeze: mem_busy=1 for 4 cycles during a load-use stall -> scoreboard unchanged, pc_write=0, stall_cnt advances by 4; pipeline resumes identically when mem_busy returns to 0.
REQ-031 Reset mid-operation: with stall=1 and stall_cnt=5, assert reset for one cycle -> all forward selects 0, stall=0, stall_cnt=0 on the next cycle.
